cpu_run_controller: RTL

//  Synthesizable run controller for one or more MIPS_cpu instances. It drives the cores' reset for a set

---
 rtl/cpu_run_pkg.sv | 17 +
 rtl/cpu_run_controller_halt_detector.sv | 97 +++++++++
 rtl/cpu_run_controller.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_run_pkg.sv
// Shared definitions for the CPU run controller: FSM state encodings and
// counter width helpers.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESET_HOLD = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } run_state_t;

  // Bits needed to hold any value in 0..max_val (never less than one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cpu_run_controller_halt_detector.sv
// halt_detector: watches one core's PC while sample_en is high and raises a
// sticky halted flag after HALT_REPEAT consecutive unchanged samples.
// RUN_TRACE_EN adds change_count, the number of sampled PC changes.
module halt_detector #(
  parameter int PC_WIDTH    = 32,
  parameter int HALT_REPEAT = 4,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                sample_en,
  input  logic                clear,
  input  logic [PC_WIDTH-1:0] pc,
  output logic                halt_next,
  output logic                halted
`ifdef RUN_TRACE_EN
  ,
  output logic [CNT_WIDTH-1:0] change_count
`endif
);

  localparam logic [CNT_WIDTH-1:0] ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] REP_HIT = CNT_WIDTH'(HALT_REPEAT);

  logic [PC_WIDTH-1:0]  prev_pc_r, prev_pc_s;
  logic                 prev_valid_r, prev_valid_s;
  logic [CNT_WIDTH-1:0] rep_r, rep_s;
  logic                 halted_r, halted_s;
`ifdef RUN_TRACE_EN
  logic [CNT_WIDTH-1:0] chg_r, chg_s;
`endif

  // Next-state for PC history, repeat counter and sticky flag; the first sample only primes prev_pc.
  always_comb begin
    prev_pc_s    = prev_pc_r;
    prev_valid_s = prev_valid_r;
    rep_s        = rep_r;
    halted_s     = halted_r;
`ifdef RUN_TRACE_EN
    chg_s        = chg_r;
`endif
    if (clear) begin
      prev_valid_s = 1'b0;
      rep_s        = ZERO;
      halted_s     = 1'b0;
`ifdef RUN_TRACE_EN
      chg_s        = ZERO;
`endif
    end else if (sample_en) begin
      prev_pc_s    = pc;
      prev_valid_s = 1'b1;
      if (!prev_valid_r) begin
        rep_s = rep_r;
      end else if (pc == prev_pc_r) begin
        rep_s    = (rep_r == CNT_MAX) ? CNT_MAX : rep_r + ONE;
        halted_s = halted_r | (rep_s == REP_HIT);
      end else begin
        rep_s = ZERO;
`ifdef RUN_TRACE_EN
        chg_s = (chg_r == CNT_MAX) ? CNT_MAX : chg_r + ONE;
`endif
      end
    end else begin
      prev_pc_s = prev_pc_r;
    end
  end

  // Detector state registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_pc_r    <= {PC_WIDTH{1'b0}};
      prev_valid_r <= 1'b0;
      rep_r        <= ZERO;
      halted_r     <= 1'b0;
`ifdef RUN_TRACE_EN
      chg_r        <= ZERO;
`endif
    end else begin
      prev_pc_r    <= prev_pc_s;
      prev_valid_r <= prev_valid_s;
      rep_r        <= rep_s;
      halted_r     <= halted_s;
`ifdef RUN_TRACE_EN
      chg_r        <= chg_s;
`endif
    end
  end

  assign halt_next = halted_s;
  assign halted    = halted_r;
`ifdef RUN_TRACE_EN
  assign change_count = chg_r;
`endif

endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: holds the cores in reset, runs them, and stops on all-halted
// or timeout. Define RUN_TRACE_EN to add the per-core pc_change_count output.
module cpu_run_controller
  import cpu_run_pkg::*;
#(
  parameter int NUM_CORES      = 1,
  parameter int PC_WIDTH       = 32,
  parameter int CNT_WIDTH      = 32,
  parameter int RESET_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 2000,
  parameter int HALT_REPEAT    = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_CORES*PC_WIDTH-1:0] core_pc,
  output logic                          core_reset,
  output logic                          running,
  output logic                          done,
  output logic                          timed_out,
  output logic [NUM_CORES-1:0]          halted,
  output logic [CNT_WIDTH-1:0]          cycle_count
`ifdef RUN_TRACE_EN
  ,
  output logic [NUM_CORES*CNT_WIDTH-1:0] pc_change_count
`endif
);

  localparam int HOLD_W = cnt_width(RESET_CYCLES);
  localparam logic [HOLD_W-1:0]    HOLD_LAST    = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [HOLD_W-1:0]    HOLD_ONE     = {{(HOLD_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO     = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE      = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX      = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  run_state_t           state_r, state_s;
  logic [HOLD_W-1:0]    hold_cnt_r, hold_cnt_s;
  logic [CNT_WIDTH-1:0] cycle_cnt_r, cycle_cnt_s;
  logic                 timed_out_r, timed_out_s;
  logic                 core_reset_r, running_r, done_r;
  logic                 start_acc_s, sample_en_s, clear_s;
  logic [NUM_CORES-1:0] halt_next_s;

  // Start is only honoured from IDLE or DONE; detectors are wiped on start and throughout the hold.
  assign start_acc_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign sample_en_s = (state_r == ST_RUN);
  assign clear_s     = start_acc_s || (state_r == ST_RESET_HOLD);

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    halt_detector #(
      .PC_WIDTH   (PC_WIDTH),
      .HALT_REPEAT(HALT_REPEAT),
      .CNT_WIDTH  (CNT_WIDTH)
    ) u_det (
      .clock       (clock),
      .reset       (reset),
      .sample_en   (sample_en_s),
      .clear       (clear_s),
      .pc          (core_pc[i*PC_WIDTH +: PC_WIDTH]),
      .halt_next   (halt_next_s[i]),
      .halted      (halted[i])
`ifdef RUN_TRACE_EN
      ,
      .change_count(pc_change_count[i*CNT_WIDTH +: CNT_WIDTH])
`endif
    );
  end

  // Next-state logic; a halt seen on the same edge as the timeout takes priority.
  always_comb begin
    state_s     = state_r;
    hold_cnt_s  = hold_cnt_r;
    cycle_cnt_s = cycle_cnt_r;
    timed_out_s = timed_out_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start_acc_s) begin
          state_s     = ST_RESET_HOLD;
          hold_cnt_s  = {HOLD_W{1'b0}};
          cycle_cnt_s = CNT_ZERO;
          timed_out_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RESET_HOLD: begin
        if (hold_cnt_r == HOLD_LAST) begin
          state_s = ST_RUN;
        end else begin
          hold_cnt_s = hold_cnt_r + HOLD_ONE;
        end
      end
      ST_RUN: begin
        if (cycle_cnt_r != CNT_MAX) begin
          cycle_cnt_s = cycle_cnt_r + CNT_ONE;
        end else begin
          cycle_cnt_s = cycle_cnt_r;
        end
        if (&halt_next_s) begin
          state_s     = ST_DONE;
          timed_out_s = 1'b0;
        end else if (cycle_cnt_r == TIMEOUT_LAST) begin
          state_s     = ST_DONE;
          timed_out_s = 1'b1;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, decoded from the next state so they align with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      hold_cnt_r   <= {HOLD_W{1'b0}};
      cycle_cnt_r  <= CNT_ZERO;
      timed_out_r  <= 1'b0;
      core_reset_r <= 1'b1;
      running_r    <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      hold_cnt_r   <= hold_cnt_s;
      cycle_cnt_r  <= cycle_cnt_s;
      timed_out_r  <= timed_out_s;
      core_reset_r <= (state_s == ST_IDLE) || (state_s == ST_RESET_HOLD);
      running_r    <= (state_s == ST_RUN);
      done_r       <= (state_s == ST_DONE);
    end
  end

  assign core_reset  = core_reset_r;
  assign running     = running_r;
  assign done        = done_r;
  assign timed_out   = timed_out_r;
  assign cycle_count = cycle_cnt_r;

endmodule
